// File: rtl/imm_gen_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_gen_pipe_pkg : format codes, RV32I opcodes and XLEN legality check
// Rev 1.0
// ---------------------------------------------------------------------------
package imm_gen_pipe_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_gen_pipe_if : instruction-in / immediate-out valid-ready bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface imm_gen_pipe_if
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     ir;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  fmt_t            fmt;
  logic            illegal;

  modport master (
    output in_valid, ir, out_ready,
    input  in_ready, out_valid, imm, fmt, illegal
  );

  modport slave (
    input  in_valid, ir, out_ready,
    output in_ready, out_valid, imm, fmt, illegal
  );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_decode : combinational RV32I immediate extraction and format classify
// Rev 1.0
// ---------------------------------------------------------------------------
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit SHAMT = 1'b1
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_shamt;

  assign w_opcode = ir[6:0];
  assign w_funct3 = ir[14:12];

  assign w_imm_i = XLEN'($signed(ir[31:20]));
  assign w_imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
  assign w_imm_b = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({ir[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
  // RV64 shifts carry a 6-bit shamt, RV32 only 5
  assign w_shamt = (XLEN == 64) ? XLEN'(ir[25:20]) : XLEN'(ir[24:20]);

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        imm = w_imm_u;
        fmt = FMT_U;
      end
      OPC_JAL: begin
        imm = w_imm_j;
        fmt = FMT_J;
      end
      OPC_JALR, OPC_LOAD, OPC_SYSTEM: begin
        imm = w_imm_i;
        fmt = FMT_I;
      end
      OPC_OP_IMM: begin
        fmt = FMT_I;
        if (SHAMT && (w_funct3 == 3'b001 || w_funct3 == 3'b101)) imm = w_shamt;
        else                                                   imm = w_imm_i;
      end
      OPC_STORE: begin
        imm = w_imm_s;
        fmt = FMT_S;
      end
      OPC_BRANCH: begin
        imm = w_imm_b;
        fmt = FMT_B;
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_gen_pipe : registered immediate generator with 2-entry skid buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit SHAMT = 1'b1
) (
  input logic          clk,
  input logic          rst,
  imm_gen_pipe_if.slave bus
);

  generate
    if (!xlen_ok(XLEN)) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_imm;
  fmt_t            r_fmt;
  logic            r_illegal;
  logic [XLEN-1:0] r_skid_imm;
  fmt_t            r_skid_fmt;
  logic            r_skid_illegal;

  logic [XLEN-1:0] w_dec_imm;
  fmt_t            w_dec_fmt;
  logic            w_dec_illegal;
  logic            w_accept;
  logic            w_take;

  imm_decode #(
    .XLEN  (XLEN),
    .SHAMT (SHAMT)
  ) u_decode (
    .ir      (bus.ir),
    .imm     (w_dec_imm),
    .fmt     (w_dec_fmt),
    .illegal (w_dec_illegal)
  );

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_take   = r_out_valid & bus.out_ready;

  // in_ready is a register so out_ready never reaches the fetch side combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_EMPTY;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_imm          <= '0;
      r_fmt          <= FMT_NONE;
      r_illegal      <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_fmt     <= FMT_NONE;
      r_skid_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_imm       <= w_dec_imm;
            r_fmt       <= w_dec_fmt;
            r_illegal   <= w_dec_illegal;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_take && w_accept) begin
            r_imm     <= w_dec_imm;
            r_fmt     <= w_dec_fmt;
            r_illegal <= w_dec_illegal;
          end else if (w_take) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end else if (w_accept) begin
            r_skid_imm     <= w_dec_imm;
            r_skid_fmt     <= w_dec_fmt;
            r_skid_illegal <= w_dec_illegal;
            r_in_ready     <= 1'b0;
            r_state        <= ST_TWO;
          end
        end
        ST_TWO: begin
          if (w_take) begin
            r_imm      <= r_skid_imm;
            r_fmt      <= r_skid_fmt;
            r_illegal  <= r_skid_illegal;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.imm       = r_imm;
  assign bus.fmt       = r_fmt;
  assign bus.illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe : directed self-checking bench, RV32 (SHAMT=1) and RV64 (SHAMT=0)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  imm_gen_pipe_if #(.XLEN(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64)) b64 ();

  imm_gen_pipe #(.XLEN(32), .SHAMT(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .SHAMT(1'b0)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

  assign b64.in_valid  = b32.in_valid;
  assign b64.ir        = b32.ir;
  assign b64.out_ready = b32.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // apply one word for one cycle and return at the following negedge
  task automatic send(input logic [31:0] word);
    @(negedge clk);
    b32.in_valid = 1'b1;
    b32.ir       = word;
    @(negedge clk);
    b32.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b32.in_valid = 1'b0; b32.ir = '0; b32.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b32.out_valid !== 1'b0 || b32.imm !== 32'h0 || b32.fmt !== FMT_NONE ||
        b32.illegal !== 1'b0 || b32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset32 got v=%b imm=%h fmt=%0d ill=%b rdy=%b want v=0 imm=0 fmt=7 ill=0 rdy=1",
               b32.out_valid, b32.imm, b32.fmt, b32.illegal, b32.in_ready);
    end
    checks++;
    if (b64.out_valid !== 1'b0 || b64.imm !== 64'h0 || b64.fmt !== FMT_NONE) begin
      failures++;
      $display("FAIL reset64 got v=%b imm=%h fmt=%0d want v=0 imm=0 fmt=7",
               b64.out_valid, b64.imm, b64.fmt);
    end
  endtask

  task automatic test_addi();
    send(32'hFFF00093);
    checks++;
    if (b32.out_valid !== 1'b1 || b32.imm !== 32'hFFFFFFFF || b32.fmt !== FMT_I) begin
      failures++;
      $display("FAIL addi32 got v=%b imm=%h fmt=%0d want v=1 imm=ffffffff fmt=1",
               b32.out_valid, b32.imm, b32.fmt);
    end
    checks++;
    if (b64.out_valid !== 1'b1 || b64.imm !== 64'hFFFFFFFFFFFFFFFF || b64.fmt !== FMT_I) begin
      failures++;
      $display("FAIL addi64 got v=%b imm=%h fmt=%0d want v=1 imm=ffffffffffffffff fmt=1",
               b64.out_valid, b64.imm, b64.fmt);
    end
  endtask

  task automatic test_formats();
    logic [31:0] words [5] = '{32'hFE000FA3, 32'hFE000023, 32'hFE000EE3, 32'h800000EF, 32'h12345037};
    logic [31:0] exp_imm [5] = '{32'hFFFFFFFF, 32'hFFFFFFE0, 32'hFFFFFFFC, 32'hFFF00000, 32'h12345000};
    fmt_t        exp_fmt [5] = '{FMT_S, FMT_S, FMT_B, FMT_J, FMT_U};
    for (int i = 0; i < 5; i++) begin
      send(words[i]);
      checks++;
      if (b32.out_valid !== 1'b1 || b32.imm !== exp_imm[i] || b32.fmt !== exp_fmt[i] ||
          b32.illegal !== 1'b0) begin
        failures++;
        $display("FAIL fmt32[%h] got v=%b imm=%h fmt=%0d ill=%b want v=1 imm=%h fmt=%0d ill=0",
                 words[i], b32.out_valid, b32.imm, b32.fmt, b32.illegal, exp_imm[i], exp_fmt[i]);
      end
      checks++;
      if (b64.imm !== {{32{exp_imm[i][31]}}, exp_imm[i]} || b64.fmt !== exp_fmt[i]) begin
        failures++;
        $display("FAIL fmt64[%h] got imm=%h fmt=%0d want imm=%h fmt=%0d",
                 words[i], b64.imm, b64.fmt, {{32{exp_imm[i][31]}}, exp_imm[i]}, exp_fmt[i]);
      end
    end
  endtask

  task automatic test_shamt();
    send(32'h41F0D093);
    checks++;
    if (b32.imm !== 32'd31 || b32.fmt !== FMT_I) begin
      failures++;
      $display("FAIL shamt_on got imm=%h fmt=%0d want imm=1f fmt=1", b32.imm, b32.fmt);
    end
    checks++;
    if (b64.imm !== 64'h41F || b64.fmt !== FMT_I) begin
      failures++;
      $display("FAIL shamt_off got imm=%h fmt=%0d want imm=41f fmt=1", b64.imm, b64.fmt);
    end
    // slli x1,x1,32 only exists on RV64; RV32 shamt keeps bits 24:20
    send(32'h02009093);
    checks++;
    if (b32.imm !== 32'd0) begin
      failures++;
      $display("FAIL shamt_5bit got imm=%h want imm=0", b32.imm);
    end
  endtask

  task automatic test_illegal_r();
    send(32'h0000007F);
    checks++;
    if (b32.illegal !== 1'b1 || b32.fmt !== FMT_NONE || b32.imm !== 32'h0 || b32.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL illegal got v=%b ill=%b fmt=%0d imm=%h want v=1 ill=1 fmt=7 imm=0",
               b32.out_valid, b32.illegal, b32.fmt, b32.imm);
    end
    send(32'h00B50533);
    checks++;
    if (b32.illegal !== 1'b0 || b32.fmt !== FMT_R || b32.imm !== 32'h0) begin
      failures++;
      $display("FAIL rtype got ill=%b fmt=%0d imm=%h want ill=0 fmt=0 imm=0",
               b32.illegal, b32.fmt, b32.imm);
    end
    @(negedge clk);
    checks++;
    if (b32.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain got v=%b want v=0", b32.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    b32.out_ready = 1'b0;
    b32.in_valid  = 1'b1;
    b32.ir        = 32'h00500093;
    @(negedge clk);
    checks++;
    if (b32.out_valid !== 1'b1 || b32.imm !== 32'd5 || b32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first got v=%b imm=%h rdy=%b want v=1 imm=5 rdy=1",
               b32.out_valid, b32.imm, b32.in_ready);
    end
    b32.ir = 32'h00600093;
    @(negedge clk);
    checks++;
    if (b32.in_ready !== 1'b0 || b32.imm !== 32'd5) begin
      failures++;
      $display("FAIL bp_full got rdy=%b imm=%h want rdy=0 imm=5", b32.in_ready, b32.imm);
    end
    b32.ir = 32'h00700093;
    repeat (2) @(negedge clk);
    checks++;
    if (b32.in_ready !== 1'b0 || b32.imm !== 32'd5 || b32.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold got v=%b rdy=%b imm=%h want v=1 rdy=0 imm=5",
               b32.out_valid, b32.in_ready, b32.imm);
    end
    b32.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (b32.imm !== 32'd6 || b32.in_ready !== 1'b1 || b32.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_skid got v=%b rdy=%b imm=%h want v=1 rdy=1 imm=6",
               b32.out_valid, b32.in_ready, b32.imm);
    end
    @(negedge clk);
    b32.in_valid = 1'b0;
    checks++;
    if (b32.imm !== 32'd7 || b32.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_third got v=%b imm=%h want v=1 imm=7", b32.out_valid, b32.imm);
    end
    @(negedge clk);
    checks++;
    if (b32.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty got v=%b want v=0", b32.out_valid);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    b32.out_ready = 1'b0;
    b32.in_valid  = 1'b1;
    b32.ir        = 32'h00100093;
    repeat (2) @(negedge clk);
    b32.in_valid = 1'b0;
    checks++;
    if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL ar_two got v=%b rdy=%b want v=1 rdy=0", b32.out_valid, b32.in_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (b32.out_valid !== 1'b0 || b32.imm !== 32'h0 || b32.fmt !== FMT_NONE) begin
      failures++;
      $display("FAIL ar_immediate got v=%b imm=%h fmt=%0d want v=0 imm=0 fmt=7",
               b32.out_valid, b32.imm, b32.fmt);
    end
    @(negedge clk);
    rst = 1'b0;
    b32.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ar_release got rdy=%b v32=%b v64=%b want rdy=1 v32=0 v64=0",
               b32.in_ready, b32.out_valid, b64.out_valid);
    end
    send(32'h00800093);
    checks++;
    if (b32.out_valid !== 1'b1 || b32.imm !== 32'd8) begin
      failures++;
      $display("FAIL ar_resume got v=%b imm=%h want v=1 imm=8", b32.out_valid, b32.imm);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_addi();
    test_formats();
    test_shamt();
    test_illegal_r();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
